// File: rtl/booth_mult_65.sv
// Sequential radix-2 Booth multiplier: 32x32 signed, one iteration per cycle over a
// 65-bit {hi, lo, q_minus1} product register, with a registered result/overflow/ready interface.
module booth_mult_65 (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_mult,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [4:0]  step,
    output logic [64:0] prod_reg
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [64:0] prod_q, prod_d;
    logic [4:0]  step_q, step_d;
    logic        busy_q, busy_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    // Booth step datapath: 33-bit add/sub keeps the true sign even for mcand = -2^31.
    logic [32:0] hi_ext;
    logic [32:0] mcand_ext;
    logic [32:0] sum;
    logic [64:0] shifted;
    logic        overflow;

    assign hi_ext    = {prod_q[64], prod_q[64:33]};
    assign mcand_ext = {mcand_q[31], mcand_q};

    always_comb begin
        // NOTE: every branch of a combinational block must assign its outputs; the
        // default up front keeps unlisted cases from inferring a latch.
        sum = hi_ext;
        case (prod_q[1:0])
            2'b01:   sum = hi_ext + mcand_ext;
            2'b10:   sum = hi_ext - mcand_ext;
            default: sum = hi_ext;
        endcase
    end

    // Arithmetic right shift of {s, lo, q_minus1}; s[32] becomes the new MSB.
    assign shifted = {sum, prod_q[32:1]};

    // Product P = prod_q[64:1]; it fits in 32 bits iff P[63:31] is a pure sign run.
    assign overflow = (|prod_q[64:32]) && !(&prod_q[64:32]);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        step_d   = step_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (ctrl_mult) begin
            // A start in any state (re)loads; an aborted run never strobes ready.
            mcand_d = data_operandA;
            prod_d  = {32'b0, data_operandB, 1'b0};
            step_d  = 5'd0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    prod_d = shifted;
                    step_d = step_q + 5'd1;
                    if (step_q == 5'd31) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    result_d = prod_q[32:1];
                    exc_d    = overflow;
                    rdy_d    = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Busy stays high through the ready cycle that follows DONE.
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            prod_q   <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
    assign step           = step_q;
    assign prod_reg       = prod_q;

endmodule

// File: tb/tb_booth_mult_65.sv
// Self-checking bench for booth_mult_65: directed and random products against a signed
// arithmetic model, per-step product register checks, restart/abort and async reset.
module tb_booth_mult_65;

    logic        clock;
    logic        reset;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [4:0]  step;
    logic [64:0] prod_reg;

    int vectors;
    int miscompares;
    logic [31:0] last_result;
    logic        last_exc;

    booth_mult_65 dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .step           (step),
        .prod_reg       (prod_reg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Signed product model: low word and whether the product leaves 32-bit signed range.
    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] pv;
        p  = longint'($signed(a)) * longint'($signed(b));
        pv = p;
        return pv[31:0];
    endfunction

    function automatic logic model_exc(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return (p > longint'(32'sh7fffffff)) || (p < -longint'(64'h80000000));
    endfunction

    // After k iterations the register holds {A * signed(B[k-1:0]) in 32+k bits, B[31:k], B[k-1]}.
    function automatic logic [64:0] booth_ref(input logic [31:0] a, input logic [31:0] b, input int k);
        longint bk;
        longint p;
        logic [64:0] r;
        bk = 0;
        if (k > 0) begin
            bk = longint'(b) & ((longint'(1) << k) - 1);
            if (b[k-1]) bk = bk - (longint'(1) << k);
        end
        p = longint'($signed(a)) * bk;
        r = 65'(p) << (33 - k);
        r = r | ((65'(b) >> k) << 1);
        if (k > 0) r[0] = b[k-1];
        return r;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_mult     = 1'b1;
        tick();
        ctrl_mult     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Waits (bounded) for the ready strobe; lat is cycles after the start edge, -1 on timeout.
    task automatic wait_rdy(output int lat, output int busy_pre);
        lat      = -1;
        busy_pre = busy ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (data_resultRDY) begin
                lat = c;
                break;
            end
            if (c < 32 && busy) busy_pre++;
        end
    endtask

    task automatic run_and_check(input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        int bp;
        start_op(a, b);
        wait_rdy(lat, bp);
        check({tag, "_lat"}, 65'(lat), 65'd33);
        check({tag, "_result"}, 65'(data_result), 65'(model_result(a, b)));
        check({tag, "_exc"}, 65'(data_exception), 65'(model_exc(a, b)));
        last_result = model_result(a, b);
        last_exc    = model_exc(a, b);
        tick();
        check({tag, "_rdy_drop"}, 65'(data_resultRDY), 65'd0);
        check({tag, "_busy_drop"}, 65'(busy), 65'd0);
    endtask

    task automatic sel_check(input logic [31:0] a, input logic [31:0] b, input string tag);
        start_op(a, b);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s_step%0d", tag, k), 65'(step), 65'(k));
            check($sformatf("%s_prod%0d", tag, k), prod_reg, booth_ref(a, b, k));
            tick();
        end
        check({tag, "_step_wrap"}, 65'(step), 65'd0);
        check({tag, "_prod_final"}, prod_reg, booth_ref(a, b, 32));
        tick();
        check({tag, "_rdy"}, 65'(data_resultRDY), 65'd1);
        check({tag, "_result"}, 65'(data_result), 65'(model_result(a, b)));
        last_result = model_result(a, b);
        last_exc    = model_exc(a, b);
        tick();
    endtask

    initial begin
        int lat;
        int bp;
        int rdy_seen;
        vectors       = 0;
        miscompares   = 0;
        last_result   = '0;
        last_exc      = 1'b0;
        reset         = 1'b0;
        ctrl_mult     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        // Reset state
        repeat (2) tick();
        check("rst_result", 65'(data_result), 65'd0);
        check("rst_exc", 65'(data_exception), 65'd0);
        check("rst_rdy", 65'(data_resultRDY), 65'd0);
        check("rst_busy", 65'(busy), 65'd0);
        check("rst_step", 65'(step), 65'd0);
        check("rst_prod", prod_reg, 65'd0);
        reset = 1'b1;
        tick();

        // 3 x 5 with latency and busy profile
        start_op(32'd3, 32'd5);
        check("m3x5_busy0", 65'(busy), 65'd1);
        wait_rdy(lat, bp);
        check("m3x5_lat", 65'(lat), 65'd33);
        check("m3x5_busy_run_cycles", 65'(bp), 65'd32);
        check("m3x5_busy_rdy", 65'(busy), 65'd1);
        check("m3x5_result", 65'(data_result), 65'h0000000F);
        check("m3x5_exc", 65'(data_exception), 65'd0);
        tick();
        check("m3x5_rdy_drop", 65'(data_resultRDY), 65'd0);
        check("m3x5_busy_drop", 65'(busy), 65'd0);
        check("m3x5_hold", 65'(data_result), 65'h0000000F);

        // Directed corner cases
        run_and_check(32'hFFFFFFF9, 32'd6, "neg7x6");
        check("neg7x6_const", 65'(data_result), 65'hFFFFFFD6);
        run_and_check(32'h80000000, 32'd1, "min_x1");
        run_and_check(32'h00010000, 32'h00010000, "ovf_pos");
        check("ovf_pos_const", 65'(data_exception), 65'd1);
        run_and_check(32'h80000000, 32'hFFFFFFFF, "min_xneg1");
        run_and_check(32'h80000000, 32'h80000000, "min_xmin");
        run_and_check(32'h7FFFFFFF, 32'h7FFFFFFF, "max_xmax");
        run_and_check(32'h0, 32'h80000000, "zero_xmin");

        // Random operands, including small-magnitude ones that stay in range
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($signed(16'($urandom)));
            run_and_check(ra, rb, $sformatf("rand%0d", i));
        end

        // Restart mid-run at cycle 10: one ready, 33 cycles after the second start
        start_op(32'd3, 32'd5);
        repeat (9) tick();
        start_op(32'd4, 32'd4);
        wait_rdy(lat, bp);
        check("restart_lat", 65'(lat), 65'd33);
        check("restart_result", 65'(data_result), 65'h10);
        last_result = 32'h10;
        last_exc    = 1'b0;
        tick();

        // Abort during the DONE cycle: no strobe, previous result held
        start_op(32'h00010000, 32'h00030000);
        repeat (32) tick();
        start_op(32'hFFFFFFFE, 32'd21);
        check("abort_done_rdy", 65'(data_resultRDY), 65'd0);
        check("abort_done_result", 65'(data_result), 65'(last_result));
        check("abort_done_exc", 65'(data_exception), 65'(last_exc));
        wait_rdy(lat, bp);
        check("abort_done_lat", 65'(lat), 65'd33);
        check("abort_done_new", 65'(data_result), 65'(model_result(32'hFFFFFFFE, 32'd21)));
        tick();

        // Asynchronous reset between edges, mid-iteration
        start_op(32'd7, 32'd9);
        repeat (12) tick();
        #2 reset = 1'b0;
        #1;
        check("async_rst_result", 65'(data_result), 65'd0);
        check("async_rst_exc", 65'(data_exception), 65'd0);
        check("async_rst_rdy", 65'(data_resultRDY), 65'd0);
        check("async_rst_busy", 65'(busy), 65'd0);
        check("async_rst_step", 65'(step), 65'd0);
        check("async_rst_prod", prod_reg, 65'd0);
        tick();
        reset = 1'b1;
        rdy_seen = 0;
        for (int c = 0; c < 35; c++) begin
            tick();
            if (data_resultRDY) rdy_seen++;
        end
        check("async_rst_no_rdy", 65'(rdy_seen), 65'd0);
        run_and_check(32'd2, 32'd2, "post_rst_2x2");
        check("post_rst_2x2_const", 65'(data_result), 65'd4);

        // Product register seen by the downstream selector, step by step
        sel_check(32'd5, 32'd3, "sel5x3");
        sel_check($urandom, $urandom, "sel_rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
